morse_decoder: RTL and testbench

Receives the serial Morse dot/dash line produced by the letter encoder (one unit = UNIT clock cycles, 250 cycles = 0.5 s at 500 Hz) and recovers the 3-bit letter code A–H. It measures mark and space run lengths, classifies each mark as a dot or a dash, and detects the end of a letter from a long space. It then emits the matching code with a one-cycle valid pulse, or a one-cycle error pulse. It sits directly downstream of the encoder on the same clock.

---
 rtl/morse_decoder_if.sv | 31 +++
 rtl/morse_decoder.sv | 170 +++++++++++++++++
 tb/tb_morse_decoder.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/morse_decoder_if.sv
// Morse decoder signal bundle.
// The upstream side drives the serial line. The decoder side returns the
// recovered letter, the valid and error pulses, and the busy flag.
//   DotDashIn   : serial Morse line, 1 = tone
//   Letter      : last decoded letter code, 000=A ... 111=H
//   LetterValid : one-cycle pulse, Letter updated on the same edge
//   Error       : one-cycle pulse on malformed, unknown or stuck input
//   Busy        : high while a letter is in progress or the line is stuck
interface morse_decoder_if;
    logic       DotDashIn;
    logic [2:0] Letter;
    logic       LetterValid;
    logic       Error;
    logic       Busy;

    modport master (
        output DotDashIn,
        input  Letter,
        input  LetterValid,
        input  Error,
        input  Busy
    );

    modport slave (
        input  DotDashIn,
        output Letter,
        output LetterValid,
        output Error,
        output Busy
    );
endinterface

// File: rtl/morse_decoder.sv
// Morse decoder for letters A-H.
// The decoder measures mark and space run lengths on the serial line and
// classifies each mark as a dot or a dash. A long space ends the letter, and
// the buffered symbols are then mapped to a 3-bit letter code.
//   ClockIn : system clock, all logic on posedge
//   Resetn  : asynchronous active-low reset
//   bus     : slave side of morse_decoder_if (line in, letter/pulses/busy out)
module morse_decoder #(
    parameter int UNIT  = 250,
    parameter int CNT_W = 10
) (
    input  logic            ClockIn,
    input  logic            Resetn,
    morse_decoder_if.slave  bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MARK  = 2'd1;
    localparam logic [1:0] SPACE = 2'd2;
    localparam logic [1:0] STUCK = 2'd3;

    // Last legal mark count; one more high sample means the line is stuck.
    localparam logic [CNT_W-1:0] MARK_MAX = CNT_W'(4 * UNIT - 1);
    // Shortest mark that counts as a dash.
    localparam logic [CNT_W-1:0] DASH_MIN = CNT_W'(2 * UNIT);
    // A space that reaches this count on a low sample ends the letter.
    localparam logic [CNT_W-1:0] GAP_MAX  = CNT_W'(2 * UNIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       sym_q, sym_d;     // bit i = symbol i, dot=0 dash=1
    logic [2:0]       len_q, len_d;
    logic             ovf_q, ovf_d;
    logic [2:0]       letter_q, letter_d;
    logic             valid_q, valid_d;
    logic             error_q, error_d;
    logic             busy_q, busy_d;
    logic [3:0]       dec_s;            // {match, code}

    // Map a symbol buffer of the given length to {match, letter code}.
    function automatic logic [3:0] decode_f(input logic [2:0] len,
                                            input logic [3:0] syms);
        logic [3:0] res;
        case ({len, syms})
            7'b001_0000: res = 4'b1_100;  // .    E
            7'b010_0010: res = 4'b1_000;  // .-   A
            7'b011_0001: res = 4'b1_011;  // -..  D
            7'b011_0011: res = 4'b1_110;  // --.  G
            7'b100_0001: res = 4'b1_001;  // -... B
            7'b100_0101: res = 4'b1_010;  // -.-. C
            7'b100_0100: res = 4'b1_101;  // ..-. F
            7'b100_0000: res = 4'b1_111;  // .... H
            default:     res = 4'b0_000;
        endcase
        return res;
    endfunction

    assign dec_s = decode_f(len_q, sym_q);

    // Next-state logic: run-length measurement, symbol buffering and decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sym_d    = sym_q;
        len_d    = len_q;
        ovf_d    = ovf_q;
        letter_d = letter_q;
        valid_d  = 1'b0;
        error_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.DotDashIn) begin
                    state_d = MARK;
                    cnt_d   = CNT_ONE;
                end else begin
                    state_d = IDLE;
                end
            end
            MARK: begin
                if (bus.DotDashIn) begin
                    if (cnt_q < MARK_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end else begin
                        error_d = 1'b1;
                        sym_d   = 4'b0000;
                        len_d   = 3'd0;
                        ovf_d   = 1'b0;
                        state_d = STUCK;
                    end
                end else begin
                    // A fifth symbol only flags overflow; the buffer stays frozen.
                    if (len_q < 3'd4) begin
                        sym_d[len_q[1:0]] = (cnt_q >= DASH_MIN);
                        len_d = len_q + 3'd1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    state_d = SPACE;
                    cnt_d   = CNT_ONE;
                end
            end
            SPACE: begin
                if (bus.DotDashIn) begin
                    state_d = MARK;
                    cnt_d   = CNT_ONE;
                end else if (cnt_q < GAP_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    if (dec_s[3] && !ovf_q) begin
                        letter_d = dec_s[2:0];
                        valid_d  = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                    sym_d   = 4'b0000;
                    len_d   = 3'd0;
                    ovf_d   = 1'b0;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = IDLE;
                end
            end
            STUCK: begin
                if (!bus.DotDashIn) begin
                    state_d = IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = STUCK;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
        // Busy also covers the cycle that carries the decode pulse.
        busy_d = (state_d != IDLE) || valid_d || error_d;
    end

    // State, counter, symbol buffer and registered outputs.
    always_ff @(posedge ClockIn or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            sym_q    <= 4'b0000;
            len_q    <= 3'd0;
            ovf_q    <= 1'b0;
            letter_q <= 3'b000;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sym_q    <= sym_d;
            len_q    <= len_d;
            ovf_q    <= ovf_d;
            letter_q <= letter_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.Letter      = letter_q;
    assign bus.LetterValid = valid_q;
    assign bus.Error       = error_q;
    assign bus.Busy        = busy_q;

endmodule

// File: tb/tb_morse_decoder.sv
// Directed bench for morse_decoder with UNIT=4.
module tb_morse_decoder;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;
    int   nv;
    int   ne;

    morse_decoder_if bus();

    morse_decoder #(.UNIT(4), .CNT_W(10)) dut (
        .ClockIn (clk),
        .Resetn  (rstn),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] n;          // number of marks
        logic [4:0] sym;        // bit i = mark i is a dash
        logic [7:0] dot_len;
        logic [7:0] dash_len;
        logic       exp_v;
        logic       exp_e;
        logic [2:0] exp_letter;
    } vec_t;

    vec_t tbl [11];

    function automatic vec_t mk(input logic [2:0] n, input logic [4:0] sym,
                                input logic [7:0] dl, input logic [7:0] hl,
                                input logic ev, input logic ee,
                                input logic [2:0] el);
        vec_t v;
        v.n = n; v.sym = sym; v.dot_len = dl; v.dash_len = hl;
        v.exp_v = ev; v.exp_e = ee; v.exp_letter = el;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one sample, let the edge take it, then observe the outputs.
    task automatic step(input logic v);
        bus.DotDashIn = v;
        @(posedge clk);
        #1;
        if (bus.LetterValid) nv++;
        if (bus.Error) ne++;
        check("valid_error_exclusive", int'(bus.LetterValid && bus.Error), 0);
    endtask

    // Marks separated by 4-low gaps, last mark followed by 8 lows.
    task automatic run_letter(input vec_t v);
        nv = 0;
        ne = 0;
        for (int i = 0; i < int'(v.n); i++) begin
            repeat (v.sym[i] ? v.dash_len : v.dot_len) step(1'b1);
            if (i < int'(v.n) - 1) repeat (4) step(1'b0);
            else repeat (8) step(1'b0);
        end
    endtask

    task automatic check_letter(input vec_t v, input string tag);
        check({tag, "_valid_at_end"}, int'(bus.LetterValid), int'(v.exp_v));
        check({tag, "_error_at_end"}, int'(bus.Error), int'(v.exp_e));
        check({tag, "_letter"}, int'(bus.Letter), int'(v.exp_letter));
        check({tag, "_valid_count"}, nv, int'(v.exp_v));
        check({tag, "_error_count"}, ne, int'(v.exp_e));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        nv = 0;
        ne = 0;
        tbl[0]  = mk(3'd4, 5'b00001, 8'd4, 8'd12, 1'b1, 1'b0, 3'b001); // B
        tbl[1]  = mk(3'd4, 5'b00101, 8'd4, 8'd12, 1'b1, 1'b0, 3'b010); // C
        tbl[2]  = mk(3'd3, 5'b00001, 8'd4, 8'd12, 1'b1, 1'b0, 3'b011); // D
        tbl[3]  = mk(3'd1, 5'b00000, 8'd4, 8'd12, 1'b1, 1'b0, 3'b100); // E
        tbl[4]  = mk(3'd4, 5'b00100, 8'd4, 8'd12, 1'b1, 1'b0, 3'b101); // F
        tbl[5]  = mk(3'd3, 5'b00011, 8'd4, 8'd12, 1'b1, 1'b0, 3'b110); // G
        tbl[6]  = mk(3'd4, 5'b00000, 8'd4, 8'd12, 1'b1, 1'b0, 3'b111); // H
        tbl[7]  = mk(3'd2, 5'b00010, 8'd4, 8'd12, 1'b1, 1'b0, 3'b000); // A
        tbl[8]  = mk(3'd1, 5'b00000, 8'd7, 8'd12, 1'b1, 1'b0, 3'b100); // 7-high dot -> E
        tbl[9]  = mk(3'd1, 5'b00001, 8'd4, 8'd8,  1'b0, 1'b1, 3'b100); // 8-high dash, unknown
        tbl[10] = mk(3'd5, 5'b00000, 8'd4, 8'd12, 1'b0, 1'b1, 3'b100); // five dots, overflow

        // Reset values before any clock edge
        rstn = 1'b0;
        bus.DotDashIn = 1'b0;
        #2;
        check("rst_letter", int'(bus.Letter), 0);
        check("rst_valid", int'(bus.LetterValid), 0);
        check("rst_error", int'(bus.Error), 0);
        check("rst_busy", int'(bus.Busy), 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // E first so the mid-letter reset has a nonzero Letter to clear
        run_letter(tbl[3]);
        check_letter(tbl[3], "pre_rst_E");

        // Asynchronous reset in the middle of a dash
        repeat (6) step(1'b1);
        check("mid_dash_busy", int'(bus.Busy), 1);
        rstn = 1'b0;
        #1;
        check("async_rst_letter", int'(bus.Letter), 0);
        check("async_rst_valid", int'(bus.LetterValid), 0);
        check("async_rst_error", int'(bus.Error), 0);
        check("async_rst_busy", int'(bus.Busy), 0);
        bus.DotDashIn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        run_letter(tbl[3]);
        check_letter(tbl[3], "post_rst_E");

        // Letter A, then Busy drops on the following idle cycle
        nv = 0;
        ne = 0;
        repeat (4) step(1'b1);
        repeat (4) step(1'b0);
        repeat (12) step(1'b1);
        repeat (7) step(1'b0);
        check("A_no_early_valid", nv, 0);
        step(1'b0);
        check("A_valid", int'(bus.LetterValid), 1);
        check("A_letter", int'(bus.Letter), 0);
        step(1'b0);
        check("A_busy_after", int'(bus.Busy), 0);
        check("A_valid_after", int'(bus.LetterValid), 0);

        // Table: all eight letters back-to-back, then the boundary/error cases
        for (int i = 0; i < 11; i++) begin
            run_letter(tbl[i]);
            check_letter(tbl[i], $sformatf("vec%0d", i));
        end

        // Stuck line: sixteenth high raises Error, Busy held until the line drops
        nv = 0;
        ne = 0;
        repeat (15) step(1'b1);
        check("stuck_no_early_error", ne, 0);
        step(1'b1);
        check("stuck_error", int'(bus.Error), 1);
        check("stuck_busy", int'(bus.Busy), 1);
        repeat (3) step(1'b1);
        check("stuck_error_once", ne, 1);
        check("stuck_busy_held", int'(bus.Busy), 1);
        step(1'b0);
        check("stuck_released_busy", int'(bus.Busy), 0);
        check("stuck_no_valid", nv, 0);

        // Gap boundary: a 7-low gap keeps the letter open, giving D
        nv = 0;
        ne = 0;
        repeat (12) step(1'b1);
        repeat (7) step(1'b0);
        check("gap7_no_pulse", nv + ne, 0);
        repeat (4) step(1'b1);
        repeat (4) step(1'b0);
        repeat (4) step(1'b1);
        repeat (8) step(1'b0);
        check("gap_D_valid", int'(bus.LetterValid), 1);
        check("gap_D_letter", int'(bus.Letter), 3);
        check("gap_D_valid_count", nv, 1);
        check("gap_D_error_count", ne, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
